// File: rtl/tx_link_pkg.sv
// ---------------------------------------------------------------------------
// tx_link_pkg
// Shared definitions for the JESD204B TX lane encoder path:
//   - octet / code-group widths
//   - running-disparity encodings (RD_NEG / RD_POS)
//   - K-character octet constants
//   - rom_word_t: one 8b/10b ROM entry {k_err, code}
//   - enc_8b10b(): table function used to fill the RD+ and RD- ROMs
// Code groups are abcdeifghj with 'a' as bit 9.
// ---------------------------------------------------------------------------
package tx_link_pkg;

  localparam int OCT_W = 8;
  localparam int CG_W  = 10;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_4 = 8'h9C;
  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_6 = 8'hDC;
  localparam logic [7:0] K28_7 = 8'hFC;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  typedef struct packed {
    logic            k_err;
    logic [CG_W-1:0] code;
  } rom_word_t;

  // 5b/6b sub-block (abcdei) as used when the current disparity is negative.
  function automatic logic [5:0] enc6_neg(input logic [4:0] x);
    enc6_neg = 6'b000000;
    case (x)
      5'd0:  enc6_neg = 6'b100111;
      5'd1:  enc6_neg = 6'b011101;
      5'd2:  enc6_neg = 6'b101101;
      5'd3:  enc6_neg = 6'b110001;
      5'd4:  enc6_neg = 6'b110101;
      5'd5:  enc6_neg = 6'b101001;
      5'd6:  enc6_neg = 6'b011001;
      5'd7:  enc6_neg = 6'b111000;
      5'd8:  enc6_neg = 6'b111001;
      5'd9:  enc6_neg = 6'b100101;
      5'd10: enc6_neg = 6'b010101;
      5'd11: enc6_neg = 6'b110100;
      5'd12: enc6_neg = 6'b001101;
      5'd13: enc6_neg = 6'b101100;
      5'd14: enc6_neg = 6'b011100;
      5'd15: enc6_neg = 6'b010111;
      5'd16: enc6_neg = 6'b011011;
      5'd17: enc6_neg = 6'b100011;
      5'd18: enc6_neg = 6'b010011;
      5'd19: enc6_neg = 6'b110010;
      5'd20: enc6_neg = 6'b001011;
      5'd21: enc6_neg = 6'b101010;
      5'd22: enc6_neg = 6'b011010;
      5'd23: enc6_neg = 6'b111010;
      5'd24: enc6_neg = 6'b110011;
      5'd25: enc6_neg = 6'b100110;
      5'd26: enc6_neg = 6'b010110;
      5'd27: enc6_neg = 6'b110110;
      5'd28: enc6_neg = 6'b001110;
      5'd29: enc6_neg = 6'b101110;
      5'd30: enc6_neg = 6'b011110;
      5'd31: enc6_neg = 6'b101011;
      default: enc6_neg = 6'b000000;
    endcase
  endfunction

  // 3b/4b sub-block (fghj) for data, when disparity after the 6b block is negative.
  function automatic logic [3:0] enc4d_neg(input logic [2:0] y);
    enc4d_neg = 4'b0000;
    case (y)
      3'd0: enc4d_neg = 4'b1011;
      3'd1: enc4d_neg = 4'b1001;
      3'd2: enc4d_neg = 4'b0101;
      3'd3: enc4d_neg = 4'b1100;
      3'd4: enc4d_neg = 4'b1101;
      3'd5: enc4d_neg = 4'b1010;
      3'd6: enc4d_neg = 4'b0110;
      3'd7: enc4d_neg = 4'b1110;
      default: enc4d_neg = 4'b0000;
    endcase
  endfunction

  // 3b/4b sub-block for control characters, disparity after 6b block negative.
  function automatic logic [3:0] enc4k_neg(input logic [2:0] y);
    enc4k_neg = 4'b0000;
    case (y)
      3'd0: enc4k_neg = 4'b1011;
      3'd1: enc4k_neg = 4'b0110;
      3'd2: enc4k_neg = 4'b1010;
      3'd3: enc4k_neg = 4'b1100;
      3'd4: enc4k_neg = 4'b1101;
      3'd5: enc4k_neg = 4'b0101;
      3'd6: enc4k_neg = 4'b1001;
      3'd7: enc4k_neg = 4'b0111;
      default: enc4k_neg = 4'b0000;
    endcase
  endfunction

  function automatic logic k_codable(input logic [7:0] d);
    k_codable = (d[4:0] == 5'd28) || (d == K23_7) || (d == K27_7) ||
                (d == K29_7) || (d == K30_7);
  endfunction

  // Full 8b/10b lookup for a given starting disparity. An illegal K request
  // is replaced by K28.0 (a neutral code) and flagged.
  function automatic rom_word_t enc_8b10b(input logic [7:0] d, input logic k,
                                          input logic rd);
    rom_word_t  w;
    logic [7:0] dd;
    logic [4:0] x;
    logic [2:0] y;
    logic [5:0] s6;
    logic [3:0] s4;
    logic       unb6;
    logic       rd6;
    logic       alt;
    w.k_err = k && !k_codable(d);
    dd      = w.k_err ? K28_0 : d;
    x       = dd[4:0];
    y       = dd[7:5];
    s6      = (k && (x == 5'd28)) ? 6'b001111 : enc6_neg(x);
    unb6    = ($countones(s6) != 3);
    // D.7 is balanced but still has distinct RD+ / RD- forms
    if (rd && (unb6 || (!k && (x == 5'd7)))) begin
      s6 = ~s6;
    end
    rd6 = rd ^ unb6;
    if (k) begin
      s4 = enc4k_neg(y);
      if (rd6) begin
        s4 = ~s4;
      end
    end else begin
      // alternate D.x.A7 avoids a run of five equal bits across the sub-blocks
      alt = (y == 3'd7) &&
            ((!rd6 && ((x == 5'd17) || (x == 5'd18) || (x == 5'd20))) ||
             ( rd6 && ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))));
      s4  = alt ? 4'b0111 : enc4d_neg(y);
      if (rd6 && (($countones(s4) != 2) || (y == 3'd3))) begin
        s4 = ~s4;
      end
    end
    w.code    = {s6, s4};
    enc_8b10b = w;
  endfunction

endpackage

// File: rtl/rdminus_rom.sv
// ---------------------------------------------------------------------------
// rdminus_rom
// 8b/10b code ROM for a negative starting running disparity.
// Registered read, 1 cycle latency, output holds when not enabled.
//   clk      in   clock
//   i_rd_en  in   read enable
//   i_addr   in   octet HGFEDCBA
//   i_k      in   1 = control character requested
//   o_code   out  10-bit code group abcdeifghj
//   o_k_err  out  K requested for a non-K-codable octet
// ---------------------------------------------------------------------------
module rdminus_rom
  import tx_link_pkg::*;
(
  input  logic            clk,
  input  logic            i_rd_en,
  input  logic [7:0]      i_addr,
  input  logic            i_k,
  output logic [CG_W-1:0] o_code,
  output logic            o_k_err
);

  rom_word_t w_rom [512];
  rom_word_t r_word;

  for (genvar gi = 0; gi < 512; gi++) begin : g_rom
    localparam logic [8:0] ADDR = 9'(gi);
    assign w_rom[gi] = enc_8b10b(ADDR[7:0], ADDR[8], RD_NEG);
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_word <= w_rom[{i_k, i_addr}];
    end
  end

  assign o_code  = r_word.code;
  assign o_k_err = r_word.k_err;

endmodule

// File: rtl/rdplus_rom.sv
// ---------------------------------------------------------------------------
// rdplus_rom
// 8b/10b code ROM for a positive starting running disparity.
// Registered read, 1 cycle latency, output holds when not enabled.
//   clk      in   clock
//   i_rd_en  in   read enable
//   i_addr   in   octet HGFEDCBA
//   i_k      in   1 = control character requested
//   o_code   out  10-bit code group abcdeifghj
//   o_k_err  out  K requested for a non-K-codable octet
// ---------------------------------------------------------------------------
module rdplus_rom
  import tx_link_pkg::*;
(
  input  logic            clk,
  input  logic            i_rd_en,
  input  logic [7:0]      i_addr,
  input  logic            i_k,
  output logic [CG_W-1:0] o_code,
  output logic            o_k_err
);

  rom_word_t w_rom [512];
  rom_word_t r_word;

  // address = {k, octet}
  for (genvar gi = 0; gi < 512; gi++) begin : g_rom
    localparam logic [8:0] ADDR = 9'(gi);
    assign w_rom[gi] = enc_8b10b(ADDR[7:0], ADDR[8], RD_POS);
  end

  always_ff @(posedge clk) begin
    if (i_rd_en) begin
      r_word <= w_rom[{i_k, i_addr}];
    end
  end

  assign o_code  = r_word.code;
  assign o_k_err = r_word.k_err;

endmodule

// File: rtl/tx_8b10b_encoder_rd_select.sv
// ---------------------------------------------------------------------------
// rd_select
// One link of the running-disparity chain (combinational).
//   i_rd     in   disparity before this group (1 = positive)
//   i_plus   in   code for positive disparity
//   i_minus  in   code for negative disparity
//   o_code   out  selected code group
//   o_rd     out  disparity after this group
//   o_legal  out  selected code has 4, 5 or 6 ones
// ---------------------------------------------------------------------------
module rd_select
  import tx_link_pkg::*;
(
  input  logic            i_rd,
  input  logic [CG_W-1:0] i_plus,
  input  logic [CG_W-1:0] i_minus,
  output logic [CG_W-1:0] o_code,
  output logic            o_rd,
  output logic            o_legal
);

  logic [3:0] w_ones;

  assign o_code  = i_rd ? i_plus : i_minus;
  assign w_ones  = 4'($countones(o_code));
  // any non-neutral group flips disparity
  assign o_rd    = i_rd ^ (w_ones != 4'd5);
  assign o_legal = (w_ones >= 4'd4) && (w_ones <= 4'd6);

endmodule

// File: rtl/tx_8b10b_encoder.sv
// ---------------------------------------------------------------------------
// tx_8b10b_encoder
// Multi-octet 8b/10b encoder for one TX lane, L octets per beat, octet 0
// transmitted first. Two-cycle latency, one beat per clock, no backpressure.
//   clk        in   lane clock
//   rst_n      in   asynchronous active-low reset
//   i_valid    in   input beat valid
//   i_data     in   octets, octet j at [8j+7:8j]
//   i_k        in   per-octet control flag
//   i_rd_clr   in   restart running disparity at negative for this beat
//   o_valid    out  output beat valid
//   o_data     out  code groups, group j at [10j+9:10j]
//   o_k_error  out  per-octet illegal K request flag
//   o_rd       out  running disparity after last group of last beat
// ---------------------------------------------------------------------------
module tx_8b10b_encoder
  import tx_link_pkg::*;
#(
  parameter int L = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [8*L-1:0]    i_data,
  input  logic [L-1:0]      i_k,
  input  logic              i_rd_clr,
  output logic              o_valid,
  output logic [10*L-1:0]   o_data,
  output logic [L-1:0]      o_k_error,
  output logic              o_rd
);

  logic              r_valid_d1;
  logic              r_clr_d1;
  logic              r_valid;
  logic [10*L-1:0]   r_data;
  logic [L-1:0]      r_k_error;
  logic              r_rd;

  logic              w_rd0;
  logic              w_rd_last;
  logic [10*L-1:0]   w_codes;
  logic [L-1:0]      w_kerr;
  logic [L-1:0]      w_legal;

  assign w_rd0 = r_clr_d1 ? RD_NEG : r_rd;

  for (genvar gi = 0; gi < L; gi++) begin : g_oct
    logic [CG_W-1:0] w_plus;
    logic [CG_W-1:0] w_minus;
    logic            w_kerr_p;
    logic            w_kerr_m;
    logic            w_rd_in;
    logic            w_rd_out;

    rdplus_rom u_plus (
      .clk     (clk),
      .i_rd_en (i_valid),
      .i_addr  (i_data[OCT_W*gi +: OCT_W]),
      .i_k     (i_k[gi]),
      .o_code  (w_plus),
      .o_k_err (w_kerr_p)
    );

    rdminus_rom u_minus (
      .clk     (clk),
      .i_rd_en (i_valid),
      .i_addr  (i_data[OCT_W*gi +: OCT_W]),
      .i_k     (i_k[gi]),
      .o_code  (w_minus),
      .o_k_err (w_kerr_m)
    );

    // each link takes its disparity from the previous link's output
    if (gi == 0) begin : g_first
      assign w_rd_in = w_rd0;
    end else begin : g_next
      assign w_rd_in = g_oct[gi-1].w_rd_out;
    end

    rd_select u_sel (
      .i_rd    (w_rd_in),
      .i_plus  (w_plus),
      .i_minus (w_minus),
      .o_code  (w_codes[CG_W*gi +: CG_W]),
      .o_rd    (w_rd_out),
      .o_legal (w_legal[gi])
    );

    // both ROMs carry the same error flag; follow the selected one
    assign w_kerr[gi] = w_rd_in ? w_kerr_p : w_kerr_m;
  end

  assign w_rd_last = g_oct[L-1].w_rd_out;

  // stage 1: control flags delayed alongside the ROM read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_d1 <= 1'b0;
      r_clr_d1   <= 1'b0;
    end else begin
      r_valid_d1 <= i_valid;
      r_clr_d1   <= i_rd_clr;
    end
  end

  // stage 2: output register and running disparity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_k_error <= '0;
      r_rd      <= RD_NEG;
    end else if (r_valid_d1) begin
      r_valid   <= 1'b1;
      r_data    <= w_codes;
      r_k_error <= w_kerr;
      r_rd      <= w_rd_last;
    end else begin
      r_valid <= 1'b0;
      // a clear arriving on a bubble still restarts disparity
      if (r_clr_d1) begin
        r_rd <= RD_NEG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && r_valid_d1) begin
      assert (&w_legal);
    end
  end

  assign o_valid   = r_valid;
  assign o_data    = r_data;
  assign o_k_error = r_k_error;
  assign o_rd      = r_rd;

endmodule

// File: tb/tb_tx_8b10b_encoder.sv
module tb_tx_8b10b_encoder;

  localparam int L = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            i_valid = 1'b0;
  logic [8*L-1:0]  i_data = '0;
  logic [L-1:0]    i_k = '0;
  logic            i_rd_clr = 1'b0;
  logic            o_valid;
  logic [10*L-1:0] o_data;
  logic [L-1:0]    o_k_error;
  logic            o_rd;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [39:0] data;
    logic [3:0]  kerr;
    logic        rd;
    int          stamp;
  } exp_t;

  exp_t q[$];

  tx_8b10b_encoder #(.L(L)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_k       (i_k),
    .i_rd_clr  (i_rd_clr),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_k_error (o_k_error),
    .o_rd      (o_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input string nm, input logic [31:0] d, input logic [3:0] k,
                      input logic clr, input logic [39:0] ed, input logic [3:0] ek,
                      input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    i_valid  = 1'b1;
    i_data   = d;
    i_k      = k;
    i_rd_clr = clr;
    e.name   = nm;
    e.data   = ed;
    e.kerr   = ek;
    e.rd     = er;
    e.stamp  = cyc + 2;
    q.push_back(e);
  endtask

  // beat that is expected to be discarded (no scoreboard entry)
  task automatic raw(input logic [31:0] d, input logic [3:0] k);
    @(posedge clk);
    #1;
    i_valid  = 1'b1;
    i_data   = d;
    i_k      = k;
    i_rd_clr = 1'b0;
  endtask

  task automatic idle(input logic clr);
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    i_data   = '0;
    i_k      = '0;
    i_rd_clr = clr;
  endtask

  task automatic drain();
    int n = 0;
    idle(1'b0);
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats still pending, expected 0", q.size());
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (o_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got o_data=%h with no beat pending (expected none)", o_data);
      end else begin
        automatic exp_t e = q.pop_front();
        $display("beat %s: o_data=%h o_k_error=%h o_rd=%0d cyc=%0d",
                 e.name, o_data, o_k_error, o_rd, cyc);
        chk({e.name, "_data"}, 64'(o_data), 64'(e.data));
        chk({e.name, "_kerr"}, 64'(o_k_error), 64'(e.kerr));
        chk({e.name, "_rd"}, 64'(o_rd), 64'(e.rd));
        chk({e.name, "_latency"}, 64'(cyc), 64'(e.stamp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_data", 64'(o_data), 64'h0);
    chk("rst_kerr", 64'(o_k_error), 64'h0);
    chk("rst_rd", 64'(o_rd), 64'h0);
    rst_n = 1'b1;

    // K28.5 x4 from RD-: alternating 0FA/305, RD back to negative
    send("k285_a", 32'hBCBCBCBC, 4'hF, 1'b0, {10'h305, 10'h0FA, 10'h305, 10'h0FA}, 4'h0, 1'b0);
    send("k285_b", 32'hBCBCBCBC, 4'hF, 1'b0, {10'h305, 10'h0FA, 10'h305, 10'h0FA}, 4'h0, 1'b0);
    // K28.5 then D21.5 x3 (neutral): RD ends positive
    send("k_d215", 32'hB5B5B5BC, 4'h1, 1'b0, {10'h2AA, 10'h2AA, 10'h2AA, 10'h0FA}, 4'h0, 1'b1);
    // clear with D0.0 x4: RD- codes
    send("d00_clr", 32'h00000000, 4'h0, 1'b1, {10'h274, 10'h274, 10'h274, 10'h274}, 4'h0, 1'b0);
    send("k_d215_2", 32'hB5B5B5BC, 4'h1, 1'b0, {10'h2AA, 10'h2AA, 10'h2AA, 10'h0FA}, 4'h0, 1'b1);
    // no clear, RD+: D0.0 gives 18B
    send("d00_rdpos", 32'h00000000, 4'h0, 1'b0, {10'h18B, 10'h18B, 10'h18B, 10'h18B}, 4'h0, 1'b1);
    // K requested on octet1=0x00 -> K28.0 (RD+ form 30B), flagged, RD unchanged
    send("kerr", 32'hB50000B5, 4'h2, 1'b0, {10'h2AA, 10'h18B, 10'h30B, 10'h2AA}, 4'h2, 1'b1);
    // valid pattern 1,0,0,1 starting from RD+
    send("gap_a", 32'hBCBCBCBC, 4'hF, 1'b0, {10'h0FA, 10'h305, 10'h0FA, 10'h305}, 4'h0, 1'b1);
    idle(1'b0);
    idle(1'b0);
    send("gap_b", 32'hBCBCBCBC, 4'hF, 1'b0, {10'h0FA, 10'h305, 10'h0FA, 10'h305}, 4'h0, 1'b1);
    // clear on a bubble, then D0.0 must use RD- codes
    idle(1'b1);
    idle(1'b0);
    send("clr_bubble", 32'h00000000, 4'h0, 1'b0, {10'h274, 10'h274, 10'h274, 10'h274}, 4'h0, 1'b0);
    drain();

    // bring RD positive before the reset test
    send("pre_rst", 32'hB5B5B5BC, 4'h1, 1'b0, {10'h2AA, 10'h2AA, 10'h2AA, 10'h0FA}, 4'h0, 1'b1);
    drain();

    // three beats issued; reset hits while the first is on the outputs
    raw(32'hBCBCBCBC, 4'hF);
    raw(32'h00000000, 4'h0);
    raw(32'hB5B5B5B5, 4'h0);
    #1;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'h0);
    chk("midrst_data", 64'(o_data), 64'h0);
    chk("midrst_rd", 64'(o_rd), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) idle(1'b0);
    chk("postrst_valid", 64'(o_valid), 64'h0);
    send("post_rst", 32'hBCBCBCBC, 4'hF, 1'b0, {10'h305, 10'h0FA, 10'h305, 10'h0FA}, 4'h0, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
